// File: rtl/sfp_resize_sched.sv
// sfp_resize_sched: round-robin arbiter sharing one signed fixed-point
// resize/clip datapath between NCH channels. The granted sample is floored to
// OUT_QW fractional bits, saturated to OUT_IW integer bits, then registered
// with its channel tag and clip flag. Per-channel clip statistics are kept
// for software headroom monitoring.
module sfp_resize_sched #(
    parameter int NCH    = 4,
    parameter int IN_IW  = 4,
    parameter int IN_QW  = 8,
    parameter int OUT_IW = 2,
    parameter int OUT_QW = 4,
    parameter int CNT_W  = 8,
    localparam int IN_W  = IN_IW + IN_QW,
    localparam int OUT_W = OUT_IW + OUT_QW,
    localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NCH-1:0]          in_valid,
    output logic [NCH-1:0]          in_ready,
    input  logic [NCH*IN_W-1:0]     in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_W-1:0]        out_data,
    output logic [CHW-1:0]          out_ch,
    output logic                    out_clip,
    input  logic                    clr_stats,
    output logic [NCH-1:0]          clip_sticky,
    output logic [NCH*CNT_W-1:0]    clip_cnt
);

    // Shift amounts for the fractional alignment; only one of them is ever non-zero.
    localparam int SHR = (IN_QW > OUT_QW) ? (IN_QW - OUT_QW) : 0;
    localparam int SHL = (OUT_QW > IN_QW) ? (OUT_QW - IN_QW) : 0;
    // Working width wide enough for the aligned input and both saturation bounds.
    localparam int WW  = IN_W + SHL + OUT_W + 1;

    localparam logic signed [WW-1:0] SAT_MAX = WW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [WW-1:0] SAT_MIN = -SAT_MAX - WW'(1);

    // Align fractional bits (floor when dropping LSBs), then saturate the
    // integer part. Returns {clip, data}. When the output has at least as many
    // integer bits as the input, the bounds can never be exceeded, so clip=0.
    function automatic logic [OUT_W:0] resize_sat(input logic signed [IN_W-1:0] x);
        logic signed [WW-1:0] t;
        t = WW'(x);
        t = (t >>> SHR) <<< SHL;
        if (t > SAT_MAX) begin
            resize_sat = {1'b1, SAT_MAX[OUT_W-1:0]};
        end else if (t < SAT_MIN) begin
            resize_sat = {1'b1, SAT_MIN[OUT_W-1:0]};
        end else begin
            resize_sat = {1'b0, t[OUT_W-1:0]};
        end
    endfunction

    // Saturating increment: a full counter stays full.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        cnt_inc = (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    logic [CHW-1:0]            ptr_q;
    logic [CHW-1:0]            gidx;
    logic                      found;
    logic                      can_accept;
    logic                      xfer;
    logic signed [IN_W-1:0]    samp_p0;
    logic [OUT_W:0]            res_p0;

    logic                      vld_p1;
    logic signed [OUT_W-1:0]   data_p1;
    logic [CHW-1:0]            ch_p1;
    logic                      clip_p1;

    logic [NCH-1:0]            sticky_q;
    logic [CNT_W-1:0]          cnt_q [NCH];
    logic                      stat_hit;

    assign can_accept = !vld_p1 || out_ready;

    // Round-robin search starting at the pointer; first requesting channel wins.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        for (int k = 0; k < NCH; k++) begin
            if (!found && in_valid[(int'(ptr_q) + k) % NCH]) begin
                found = 1'b1;
                gidx  = CHW'((int'(ptr_q) + k) % NCH);
            end
        end
        in_ready = (found && can_accept && !rst) ? (NCH'(1) << gidx) : '0;
    end

    assign xfer = |(in_valid & in_ready);

    // ---- stage p0: granted sample through the resize/clip datapath ----
    assign samp_p0 = in_data[gidx*IN_W +: IN_W];
    assign res_p0  = resize_sat(samp_p0);

    // Output register and pointer: load on a transfer, drain on accept, hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            ch_p1   <= '0;
            clip_p1 <= 1'b0;
            ptr_q   <= '0;
        end else if (xfer) begin
            vld_p1  <= 1'b1;
            data_p1 <= res_p0[OUT_W-1:0];
            ch_p1   <= gidx;
            clip_p1 <= res_p0[OUT_W];
            ptr_q   <= (int'(gidx) == NCH - 1) ? '0 : gidx + CHW'(1);
        end else if (out_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    // ---- stage p1: registered output ----
    assign out_valid = vld_p1;
    assign out_data  = data_p1;
    assign out_ch    = ch_p1;
    assign out_clip  = clip_p1;

    assign stat_hit = vld_p1 && out_ready && clip_p1;

    // Clip statistics: clear first, then a clip handshake on the same edge wins for its channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_q <= '0;
            for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (stat_hit && int'(ch_p1) == i) begin
                    sticky_q[i] <= 1'b1;
                    cnt_q[i]    <= clr_stats ? CNT_W'(1) : cnt_inc(cnt_q[i]);
                end else if (clr_stats) begin
                    sticky_q[i] <= 1'b0;
                    cnt_q[i]    <= '0;
                end
            end
        end
    end

    // Flatten the counters onto the packed status port.
    always_comb begin
        clip_cnt = '0;
        for (int i = 0; i < NCH; i++) clip_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end

    assign clip_sticky = sticky_q;

endmodule

// File: tb/tb_sfp_resize_sched.sv
// Directed bench for sfp_resize_sched with default parameters.
module tb_sfp_resize_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [47:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_clip;
    logic        clr_stats;
    logic [3:0]  clip_sticky;
    logic [31:0] clip_cnt;

    int nchk  = 0;
    int nfail = 0;

    sfp_resize_sched dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_ch      (out_ch),
        .out_clip    (out_clip),
        .clr_stats   (clr_stats),
        .clip_sticky (clip_sticky),
        .clip_cnt    (clip_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; return 1 time unit after the edge so outputs are stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int exp_seq1 [6] = '{0, 1, 2, 3, 0, 1};
    int exp_seq2 [5] = '{3, 0, 1, 3, 0};

    initial begin
        rst       = 1'b1;
        in_valid  = 4'hF;
        in_data   = '0;
        out_ready = 1'b1;
        clr_stats = 1'b0;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_out_clip", out_clip, 0);
        chk("rst_sticky", clip_sticky, 0);
        chk("rst_cnt", clip_cnt, 0);
        chk("rst_in_ready", in_ready, 0);
        in_valid = 4'h0;
        @(negedge clk);
        rst = 1'b0;

        // Single channel: +1.5 on ch1
        in_data[12 +: 12] = 12'h180;
        in_valid = 4'b0010;
        #1;
        chk("t1_in_ready", in_ready, 4'b0010);
        tick();
        chk("t1_valid", out_valid, 1);
        chk("t1_data", out_data, 6'h18);
        chk("t1_ch", out_ch, 1);
        chk("t1_clip", out_clip, 0);
        chk("t1_cnt", clip_cnt, 0);

        // Floor and saturation (pointer now 2; ch0 still wins when alone)
        in_data[0 +: 12]  = 12'hFFF;
        in_data[24 +: 12] = 12'h500;
        in_data[36 +: 12] = 12'hB00;
        in_valid = 4'b0001;
        tick();
        chk("floor_data", out_data, 6'h3F);
        chk("floor_clip", out_clip, 0);
        chk("floor_ch", out_ch, 0);
        in_valid = 4'b0100;
        tick();
        chk("satp_data", out_data, 6'h1F);
        chk("satp_clip", out_clip, 1);
        in_valid = 4'b1000;
        tick();
        chk("satn_data", out_data, 6'h20);
        chk("satn_clip", out_clip, 1);
        in_valid = 4'b0000;
        tick();
        chk("sat_drain_valid", out_valid, 0);
        chk("sat_sticky", clip_sticky, 4'b1100);
        chk("sat_cnt0", clip_cnt[0 +: 8], 0);
        chk("sat_cnt2", clip_cnt[16 +: 8], 1);
        chk("sat_cnt3", clip_cnt[24 +: 8], 1);

        // Fairness: all four channels requesting (pointer at 0)
        in_data  = '0;
        in_valid = 4'hF;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rr_valid", out_valid, 1);
            chk("rr_ch", out_ch, exp_seq1[i]);
        end
        in_valid = 4'b1011;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rr_skip_valid", out_valid, 1);
            chk("rr_skip_ch", out_ch, exp_seq2[i]);
        end
        in_valid = 4'b0000;
        tick();
        chk("rr_drain", out_valid, 0);

        // Backpressure (pointer at 1)
        in_data[0 +: 12]  = 12'h010;
        in_data[12 +: 12] = 12'h020;
        in_valid  = 4'b0011;
        out_ready = 1'b0;
        tick();
        chk("bp_first_ch", out_ch, 1);
        chk("bp_first_data", out_data, 6'h02);
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", in_ready, 0);
            tick();
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_ch", out_ch, 1);
            chk("bp_hold_data", out_data, 6'h02);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 4'b0001);
        tick();
        chk("bp_next_ch", out_ch, 0);
        chk("bp_next_data", out_data, 6'h01);
        tick();
        chk("bp_after_ch", out_ch, 1);
        in_valid = 4'b0000;
        tick();

        // Counter saturation: 300 clipped samples from ch0
        in_data[0 +: 12] = 12'h500;
        in_valid = 4'b0001;
        repeat (300) tick();
        in_valid = 4'b0000;
        tick();
        chk("cnt_sat0", clip_cnt[0 +: 8], 8'd255);
        chk("cnt_sat_sticky0", clip_sticky[0], 1);

        // Clear coincident with a ch0 clip handshake
        in_valid = 4'b0001;
        tick();
        chk("clr_pre_clip", out_clip, 1);
        in_valid  = 4'b0000;
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        chk("clr_cnt", clip_cnt, 32'h0000_0001);
        chk("clr_sticky", clip_sticky, 4'b0001);

        // Async reset mid-operation
        in_valid  = 4'b0001;
        out_ready = 1'b0;
        tick();
        chk("mr_pre_valid", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_valid", out_valid, 0);
        chk("mr_in_ready", in_ready, 0);
        chk("mr_sticky", clip_sticky, 0);
        @(negedge clk);
        rst       = 1'b0;
        in_valid  = 4'b1001;
        out_ready = 1'b1;
        #1;
        chk("mr_grant", in_ready, 4'b0001);
        tick();
        chk("mr_first_ch", out_ch, 0);
        chk("mr_first_valid", out_valid, 1);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1);
    end

endmodule

// File: doc/sfp_resize_sched.md
Name: sfp_resize_sched

Overview:
- Round-robin scheduler that time-shares one signed fixed-point resize/clip datapath between NCH requesting channels.
- Each channel presents samples in a common input sfp format (IN_IW.IN_QW). The block grants one channel per cycle, resizes the sample to OUT_IW.OUT_QW (floor on fractional bits, saturate on integer bits), and registers the result into a single output stage tagged with channel index and clip flag.
- Keeps per-channel clip statistics for gain/headroom monitoring by software.
- Sits between multi-channel filter outputs and a shared downstream consumer.

Parameters:
- NCH, 4, number of requesting channels (>=2)
- IN_IW, 4, input integer bits, including sign
- IN_QW, 8, input fractional bits
- OUT_IW, 2, output integer bits, including sign
- OUT_QW, 4, output fractional bits
- CNT_W, 8, width of each per-channel clip counter
- Derived: IN_W=IN_IW+IN_QW; OUT_W=OUT_IW+OUT_QW; CHW=max(1,$clog2(NCH))

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  NCH  per-channel sample valid
- in_ready  out  NCH  per-channel accept (one-hot or zero)
- in_data  in  NCH*IN_W  per-channel signed samples; channel i at [i*IN_W +: IN_W]
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accept
- out_data  out  OUT_W  resized signed sample
- out_ch  out  CHW  source channel of out_data
- out_clip  out  1  out_data was saturated
- clr_stats  in  1  single-cycle pulse: clear clip statistics
- clip_sticky  out  NCH  per-channel sticky clip flag
- clip_cnt  out  NCH*CNT_W  per-channel saturating clip counters; channel i at [i*CNT_W +: CNT_W]

Behaviour:
- Clock/reset: one clock, clk. rst is asynchronous, active-high.
- Reset values:
  - out_valid=0, out_data=0, out_ch=0, out_clip=0
  - clip_sticky=0, clip_cnt=0
  - RR pointer=0
  - in_ready=0 while rst is asserted
- can_accept = !out_valid | out_ready (output register empty, or draining this cycle).
- Arbitration (combinational):
  - Scan channels from pointer p upward, modulo NCH; the first channel with in_valid set wins.
  - in_ready[g]=can_accept for the winner only; all other in_ready bits are 0.
  - in_ready never depends on out_ready for non-winners. No combinational path from in_ready back to in_valid.
- Transfer: when in_valid[g] & in_ready[g], on the next clk edge:
  - out_data=resize(in_data[g])
  - out_ch=g
  - out_clip=clip flag
  - out_valid=1
  - p=(g+1) mod NCH
- Pointer: unchanged when no transfer occurs.
- Output hold:
  - If out_valid & !out_ready, the output register holds all fields and no grant is issued.
  - If out_valid & out_ready with no new transfer, out_valid goes to 0 next cycle.
  - Back-to-back throughput is 1 sample/cycle when out_ready=1.
- Latency: exactly 1 cycle from input handshake to out_valid.
- Resize arithmetic, combinational before the output register:
  - Fractional bits: if OUT_QW<IN_QW, drop LSBs (floor toward -inf). Otherwise zero-pad LSBs.
  - Integer bits: if OUT_IW<IN_IW, saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and set clip=1 when saturation occurs. Otherwise sign-extend, with clip=0.
  - Saturation is evaluated after truncation.
- Statistics:
  - Updated on the output handshake (out_valid & out_ready & out_clip) for channel out_ch: clip_sticky[out_ch]<=1; clip_cnt[out_ch]<=min(cnt+1, 2^CNT_W-1).
  - clr_stats zeroes all sticky flags and counters.
  - clr_stats coincident with a clip handshake: that channel ends at sticky=1, cnt=1. All other channels end at 0.
  - A counter at 2^CNT_W-1 stays there; it does not wrap.
- Async reset mid-burst:
  - The output register and pointer clear immediately; the pending output sample is discarded.
  - Arbitration restarts at channel 0 after reset deasserts.
- No channel waits more than NCH-1 grants while its in_valid is held.

Test Plan:
- Single channel, defaults: ch1 drives 0x180 (+1.5) with out_ready=1 -> one cycle later out_valid=1, out_data=0x18, out_ch=1, out_clip=0; clip_cnt unchanged.
- Floor and saturation: ch0 drives 0xFFF (-1/256) -> 0x3F, clip=0. ch2 drives 0x500 (+5.0) -> 0x1F, clip=1. ch3 drives 0xB00 (-5.0) -> 0x20, clip=1. After these: clip_sticky=4'b1100, clip_cnt[2]=clip_cnt[3]=1.
- Fairness: all four channels hold in_valid with out_ready=1 -> out_ch sequence 0,1,2,3,0,... one per cycle. Drop ch2 mid-stream -> sequence skips 2 without stalling.
- Backpressure: out_ready=0 for 5 cycles with ch0 and ch1 valid -> out_data/out_ch held stable and in_ready=0 throughout. Raise out_ready -> next sample appears on the following cycle, with no sample lost or duplicated.
- Counter saturation and clear:
  - Ch0 produces 300 clipped samples with CNT_W=8 -> clip_cnt[0]=255.
  - clr_stats on a cycle with a ch0 clip handshake -> clip_cnt[0]=1, clip_sticky[0]=1, all other channels 0.
- Reset mid-operation: assert rst while out_valid=1 and out_ready=0 -> out_valid=0 and in_ready=0 immediately. After release, with ch3 and ch0 valid, the first grant goes to ch0.
